// File: rtl/firebird7_in_gate1_tessent_tdr_runctrl_pkg.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_runctrl_pkg
// Shared definitions for the IJTAG run-control TDR:
//   - runctrl_state_e : run-control FSM states
//   - update-register field indices (START, ABORT, CLEAR, MODE, RUNLEN_LSB)
//   - capture-word layout indices and the number of status flag bits
// ---------------------------------------------------------------------------
package firebird7_in_gate1_tessent_tdr_runctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StDone    = 2'd2,
    StAborted = 2'd3
  } runctrl_state_e;

  // Update-register field positions
  localparam int unsigned START      = 0;
  localparam int unsigned ABORT      = 1;
  localparam int unsigned CLEAR      = 2;
  localparam int unsigned MODE       = 3;
  localparam int unsigned RUNLEN_LSB = 4;

  // Capture-word layout: {count, busy, done, aborted, error_sticky}
  localparam int unsigned CAP_ERROR     = 0;
  localparam int unsigned CAP_ABORTED   = 1;
  localparam int unsigned CAP_DONE      = 2;
  localparam int unsigned CAP_BUSY      = 3;
  localparam int unsigned CAP_COUNT_LSB = 4;
  localparam int unsigned CAP_FLAGS     = 4;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_core.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_core
// IJTAG test data register: capture/shift register on posedge tck, update
// register on negedge tck, and a low-transparent retiming latch on scan out.
// Ports:
//   tck_i      - IJTAG clock
//   rst_ni     - asynchronous active-low reset
//   sel_i      - segment select; all paths hold while low
//   si_i       - scan in (enters the MSB)
//   ce_i/se_i  - capture / shift enable (capture has priority)
//   ue_i       - update enable (negedge)
//   capture_i  - parallel word loaded on capture
//   so_o       - scan out, half-cycle retimed bit0
//   update_o   - update register contents
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_core #(
  parameter int unsigned TDR_WIDTH = 16
) (
  input  logic                 tck_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic                 si_i,
  input  logic                 ce_i,
  input  logic                 se_i,
  input  logic                 ue_i,
  input  logic [TDR_WIDTH-1:0] capture_i,
  output logic                 so_o,
  output logic [TDR_WIDTH-1:0] update_o
);

  logic [TDR_WIDTH-1:0] shift_d, shift_q;
  logic [TDR_WIDTH-1:0] update_q;
  logic                 so_q;

  always_comb begin
    shift_d = shift_q;
    if (sel_i && ce_i) begin
      shift_d = capture_i;
    end else if (sel_i && se_i) begin
      shift_d = {si_i, shift_q[TDR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  always_ff @(negedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      update_q <= '0;
    end else if (sel_i && ue_i) begin
      update_q <= shift_q;
    end
  end

  // Transparent while tck is low so the downstream sees bit0 launched on
  // the falling edge, giving the upstream SIB a half cycle of hold margin.
  always_latch begin
    if (!rst_ni) begin
      so_q <= 1'b0;
    end else if (!tck_i) begin
      so_q <= shift_q[0];
    end
  end

  assign so_o     = so_q;
  assign update_o = update_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_runctrl.sv
// ---------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_runctrl
// IJTAG-controlled instrument run controller. A TDR (sub-module core) holds
// {run_length, mode, clear, abort, start}; rising edges of the control bits
// drive an IDLE/RUN/DONE/ABORTED FSM with a cycle counter. Status is
// captured back as {count, busy, done, aborted, error_sticky}.
// Ports:
//   ijtag_tck, ijtag_reset     - clock, asynchronous active-low reset
//   ijtag_sel/si/ce/se/ue      - IJTAG segment controls and scan in
//   ijtag_so                   - scan out (retimed)
//   instr_error                - instrument error, sampled while running
//   instr_run, instr_done      - registered run / complete indications
//   instr_count                - current cycle count
// ---------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_runctrl
  import firebird7_in_gate1_tessent_tdr_runctrl_pkg::*;
#(
  parameter int unsigned TDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 12
) (
  input  logic                 ijtag_tck,
  input  logic                 ijtag_reset,
  input  logic                 ijtag_sel,
  input  logic                 ijtag_si,
  input  logic                 ijtag_ce,
  input  logic                 ijtag_se,
  input  logic                 ijtag_ue,
  output logic                 ijtag_so,
  input  logic                 instr_error,
  output logic                 instr_run,
  output logic                 instr_done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  logic [TDR_WIDTH-1:0] capture;
  logic [TDR_WIDTH-1:0] update;

  runctrl_state_e       state_d, state_q;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 err_d, err_q;
  logic                 run_q, done_q, aborted_q;
  logic                 start_prev_q, abort_prev_q, clear_prev_q;

  logic                 start_ev, abort_ev, clear_ev, start_go;
  logic [CNT_WIDTH-1:0] run_length;
  logic                 mode;
  logic [CNT_WIDTH:0]   last_count;
  logic                 at_last;

  firebird7_in_gate1_tessent_tdr_core #(
    .TDR_WIDTH(TDR_WIDTH)
  ) u_core (
    .tck_i    (ijtag_tck),
    .rst_ni   (ijtag_reset),
    .sel_i    (ijtag_sel),
    .si_i     (ijtag_si),
    .ce_i     (ijtag_ce),
    .se_i     (ijtag_se),
    .ue_i     (ijtag_ue),
    .capture_i(capture),
    .so_o     (ijtag_so),
    .update_o (update)
  );

  assign capture = {count_q, run_q, done_q, aborted_q, err_q};

  assign run_length = update[RUNLEN_LSB +: CNT_WIDTH];
  assign mode       = update[MODE];

  // One-cycle events on 0->1 of each control bit
  assign start_ev = update[START] & ~start_prev_q;
  assign abort_ev = update[ABORT] & ~abort_prev_q;
  assign clear_ev = update[CLEAR] & ~clear_prev_q;
  assign start_go = start_ev & ~abort_ev & ~clear_ev;

  // Extra bit keeps run_length==0 from wrapping to an all-ones match
  assign last_count = {1'b0, run_length} - {{CNT_WIDTH{1'b0}}, 1'b1};
  assign at_last    = ({1'b0, count_q} == last_count);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;

    if ((state_q == StRun) && instr_error) begin
      err_d = 1'b1;
    end
    if (clear_ev) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          count_d = '0;
          state_d = (run_length == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort_ev) begin
          state_d = StAborted;
        end else if (at_last) begin
          if (mode) begin
            count_d = '0;
          end else begin
            state_d = StDone;
            count_d = run_length;
          end
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      StDone, StAborted: begin
        if (clear_ev) begin
          state_d = StIdle;
          count_d = '0;
        end else if (start_go) begin
          count_d = '0;
          state_d = (run_length == '0) ? StDone : StRun;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      err_q        <= 1'b0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      start_prev_q <= 1'b0;
      abort_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      err_q        <= err_d;
      run_q        <= (state_d == StRun);
      done_q       <= (state_d == StDone);
      aborted_q    <= (state_d == StAborted);
      start_prev_q <= update[START];
      abort_prev_q <= update[ABORT];
      clear_prev_q <= update[CLEAR];
    end
  end

  assign instr_run   = run_q;
  assign instr_done  = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_runctrl.sv
module tb_firebird7_in_gate1_tessent_tdr_runctrl;

  logic        ijtag_tck   = 1'b0;
  logic        ijtag_reset = 1'b0;
  logic        ijtag_sel   = 1'b0;
  logic        ijtag_si    = 1'b0;
  logic        ijtag_ce    = 1'b0;
  logic        ijtag_se    = 1'b0;
  logic        ijtag_ue    = 1'b0;
  logic        instr_error = 1'b0;
  logic        ijtag_so;
  logic        instr_run;
  logic        instr_done;
  logic [11:0] instr_count;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_tdr_runctrl #(
    .TDR_WIDTH(16),
    .CNT_WIDTH(12)
  ) dut (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .ijtag_sel  (ijtag_sel),
    .ijtag_si   (ijtag_si),
    .ijtag_ce   (ijtag_ce),
    .ijtag_se   (ijtag_se),
    .ijtag_ue   (ijtag_ue),
    .ijtag_so   (ijtag_so),
    .instr_error(instr_error),
    .instr_run  (instr_run),
    .instr_done (instr_done),
    .instr_count(instr_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        run;
    logic        done;
    logic [11:0] count;
  } obs_t;

  obs_t        out_q[$];
  logic [15:0] cap_q[$];
  logic [15:0] rd_q[$];
  string       dn_q[$];
  logic [31:0] dg_q[$];
  logic [31:0] de_q[$];

  // Reference model: abstract run controller driven by what the bench wrote
  localparam int MIdle = 0, MRun = 1, MDone = 2, MAborted = 3;
  int          m_state = MIdle;
  int          m_count = 0;
  int          m_err   = 0;
  logic [15:0] m_upd   = '0;
  logic [15:0] m_pending = '0;
  logic [2:0]  m_prev  = '0;
  logic        tck_prev = 1'b0;

  always @(ijtag_tck or ijtag_reset) begin : model
    int   rl;
    int   cap_val;
    bit   st, ab, cl, go;
    obs_t o;
    if (ijtag_tck === 1'b1 && tck_prev === 1'b0) begin
      if (ijtag_reset === 1'b1) begin
        cap_val = m_count * 16 + ((m_state == MRun) ? 8 : 0) + ((m_state == MDone) ? 4 : 0)
                + ((m_state == MAborted) ? 2 : 0) + m_err;
        if (ijtag_sel && ijtag_ce) cap_q.push_back(16'(cap_val));
        st = m_upd[0] && !m_prev[0];
        ab = m_upd[1] && !m_prev[1];
        cl = m_upd[2] && !m_prev[2];
        go = st && !ab && !cl;
        rl = int'(m_upd[15:4]);
        if (m_state == MRun && instr_error === 1'b1) m_err = 1;
        if (cl) m_err = 0;
        if (m_state == MRun) begin
          if (ab) m_state = MAborted;
          else if (m_count == rl - 1) begin
            if (m_upd[3]) m_count = 0;
            else begin
              m_state = MDone;
              m_count = rl;
            end
          end else m_count = (m_count + 1) % 4096;
        end else if ((m_state == MDone || m_state == MAborted) && cl) begin
          m_state = MIdle;
          m_count = 0;
        end else if (go) begin
          m_count = 0;
          m_state = (rl == 0) ? MDone : MRun;
        end
        m_prev = m_upd[2:0];
      end
      if (ijtag_reset !== 1'b1) begin
        m_state = MIdle; m_count = 0; m_err = 0; m_upd = '0; m_prev = '0;
      end
      o.run   = (m_state == MRun);
      o.done  = (m_state == MDone);
      o.count = 12'(m_count);
      out_q.push_back(o);
    end else if (ijtag_tck === 1'b0 && tck_prev === 1'b1) begin
      if (ijtag_reset === 1'b1 && ijtag_sel && ijtag_ue) m_upd = m_pending;
    end
    if (ijtag_reset !== 1'b1) begin
      m_state = MIdle; m_count = 0; m_err = 0; m_upd = '0; m_prev = '0;
    end
    tck_prev = ijtag_tck;
  end

  // Monitor: status every cycle, scan reads as they complete, directed checks
  always @(negedge ijtag_tck) begin : monitor
    obs_t        e;
    logic [15:0] got, exp;
    string       n;
    logic [31:0] g, x;
    checks++;
    if (out_q.size() == 0) begin
      errors++;
      $display("FAIL status_queue: no expected status at time %0t", $time);
    end else begin
      e = out_q.pop_front();
      if ({instr_run, instr_done, instr_count} !== e) begin
        errors++;
        $display("FAIL status @%0t: got run=%0b done=%0b count=%0d, expected run=%0b done=%0b count=%0d",
                 $time, instr_run, instr_done, instr_count, e.run, e.done, e.count);
      end
    end
    while (rd_q.size() > 0) begin
      got = rd_q.pop_front();
      checks++;
      if (cap_q.size() == 0) begin
        errors++;
        $display("FAIL capture_queue: read 0x%04h with no expected capture", got);
      end else begin
        exp = cap_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL capture @%0t: got 0x%04h, expected 0x%04h", $time, got, exp);
        end
      end
    end
    while (dn_q.size() > 0) begin
      n = dn_q.pop_front();
      g = dg_q.pop_front();
      x = de_q.pop_front();
      checks++;
      if (g !== x) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", n, g, x);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
    dn_q.push_back(n);
    dg_q.push_back(g);
    de_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ijtag_tck);
      #1;
    end
  endtask

  task automatic scan_write(input logic [15:0] w);
    m_pending = w;
    ijtag_sel = 1'b1; ijtag_ce = 1'b0; ijtag_ue = 1'b0; ijtag_se = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ijtag_si = w[i];
      cyc(1);
    end
    ijtag_se = 1'b0; ijtag_ue = 1'b1;
    cyc(1);
    ijtag_ue = 1'b0; ijtag_sel = 1'b0; ijtag_si = 1'b0;
  endtask

  task automatic scan_read(output logic [15:0] data);
    ijtag_sel = 1'b1; ijtag_ce = 1'b1; ijtag_se = 1'b0; ijtag_si = 1'b0;
    cyc(1);
    ijtag_ce = 1'b0; ijtag_se = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge ijtag_tck);
      #1;
      data[i] = ijtag_so;
      cyc(1);
    end
    ijtag_se = 1'b0; ijtag_sel = 1'b0;
    rd_q.push_back(data);
  endtask

  initial begin : stim
    logic [15:0] d;
    logic [47:0] pat;
    logic [32:0] thru;
    int          n;
    cyc(3);
    ijtag_reset = 1'b1;
    cyc(1);
    scan_read(d);
    chk("reset_capture", 32'(d), 32'h0000);

    // Single run of 5 cycles
    scan_write(16'h0051);
    n = 0;
    repeat (10) begin
      if (instr_run === 1'b1) n++;
      cyc(1);
    end
    chk("run_cycles", 32'(n), 32'd5);
    chk("done_after_run", 32'(instr_done), 32'd1);
    scan_read(d);
    chk("single_run_capture", 32'(d), 32'h0054);

    // Zero-length run goes straight to DONE
    scan_write(16'h0004);
    scan_write(16'h0001);
    chk("zero_len_done", 32'(instr_done), 32'd1);
    chk("zero_len_run", 32'(instr_run), 32'd0);
    scan_read(d);
    chk("zero_len_capture", 32'(d), 32'h0004);

    // Continuous run, abort after 150 counted cycles
    scan_write(16'h0004);
    scan_write(16'h0649);
    cyc(134);
    scan_write(16'h064A);
    scan_read(d);
    chk("abort_capture", 32'(d), 32'h0322);
    scan_write(16'h064C);
    scan_read(d);
    chk("clear_after_abort", 32'(d), 32'h0000);

    // Sticky error survives completion and restart
    scan_write(16'h0081);
    instr_error = 1'b1;
    cyc(1);
    instr_error = 1'b0;
    cyc(12);
    scan_read(d);
    chk("error_done_capture", 32'(d), 32'h0085);
    scan_write(16'h0080);
    scan_write(16'h0081);
    scan_read(d);
    chk("error_kept_restart", 32'(d[0]), 32'd1);
    cyc(12);
    scan_write(16'h0084);
    scan_read(d);
    chk("error_cleared", 32'(d), 32'h0000);

    // Start with abort in IDLE is suppressed; then raw scan pass-through
    scan_write(16'h0003);
    cyc(2);
    chk("start_abort_run", 32'(instr_run), 32'd0);
    chk("start_abort_done", 32'(instr_done), 32'd0);
    pat = {16'($urandom), $urandom};
    thru = '0;
    ijtag_sel = 1'b1; ijtag_se = 1'b1;
    for (int j = 0; j < 48; j++) begin
      ijtag_si = pat[j];
      @(posedge ijtag_tck);
      @(negedge ijtag_tck);
      #1;
      if (j >= 15) thru[j-15] = ijtag_so;
    end
    ijtag_se = 1'b0; ijtag_sel = 1'b0; ijtag_si = 1'b0;
    cyc(1);
    chk("scan_passthrough", 32'(thru), 32'(pat[32:0]));

    // Reset mid-run
    scan_write(16'h0004);
    scan_write(16'h0321);
    cyc(10);
    @(negedge ijtag_tck);
    #1;
    ijtag_reset = 1'b0;
    #1;
    chk("reset_drops_run", 32'(instr_run), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    repeat (3) @(negedge ijtag_tck);
    #1;
    ijtag_reset = 1'b1;
    cyc(10);
    chk("no_run_after_reset", 32'(instr_run), 32'd0);
    scan_read(d);
    chk("capture_after_reset", 32'(d), 32'h0000);

    // Randomised mix of writes, reads and idle cycles with deselected noise
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: scan_write(16'(($urandom_range(0, 12) << 4) | (($urandom_range(0, 3) == 0) ? 8 : 0)
                          | $urandom_range(0, 7)));
        1: scan_read(d);
        default: begin
          repeat ($urandom_range(1, 20)) begin
            instr_error = ($urandom_range(0, 7) == 0);
            ijtag_ce = 1'($urandom); ijtag_se = 1'($urandom);
            ijtag_ue = 1'($urandom); ijtag_si = 1'($urandom);
            cyc(1);
          end
          instr_error = 1'b0;
          ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
        end
      endcase
    end

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
